// File: rtl/sb_tx_arbiter_if.sv
// Requester/pattern/TX-FSM side signals of the sideband TX arbiter.
// master = requesters and SB TX FSM, slave = arbiter.
interface sb_tx_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned MSG_W = 64
);
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*MSG_W-1:0] i_req_msg;
    logic [N_REQ-1:0]       i_req_has_data;
    logic                   i_pattern_req;
    logic                   i_pattern_done;
    logic                   i_tx_busy;
    logic [N_REQ-1:0]       o_grant;
    logic                   o_msg_valid;
    logic                   o_data_valid;
    logic [MSG_W-1:0]       o_msg;
    logic                   o_start_pattern_req;
    logic                   o_arb_busy;
    logic                   o_start_err;

    modport master (
        output i_req, i_req_msg, i_req_has_data, i_pattern_req, i_pattern_done, i_tx_busy,
        input  o_grant, o_msg_valid, o_data_valid, o_msg, o_start_pattern_req,
               o_arb_busy, o_start_err
    );

    modport slave (
        input  i_req, i_req_msg, i_req_has_data, i_pattern_req, i_pattern_done, i_tx_busy,
        output o_grant, o_msg_valid, o_data_valid, o_msg, o_start_pattern_req,
               o_arb_busy, o_start_err
    );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Shares the sideband TX path between N_REQ message requesters and the start
// pattern: pattern first, then round-robin, one packet at a time with idle gap.
module sb_tx_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned MSG_W      = 64,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned START_TO   = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    sb_tx_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TO_W  = $clog2(START_TO + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAT,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [TO_W-1:0]  r_to_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [N_REQ-1:0] r_grant;
    logic             r_msg_valid;
    logic             r_data_valid;
    logic [MSG_W-1:0] r_msg;
    logic             r_start_pattern_req;
    logic             r_arb_busy;
    logic             r_start_err;

    logic             w_any;
    logic [PTR_W-1:0] w_win;
    logic [MSG_W-1:0] w_win_msg;
    logic             w_win_data;

    // Round-robin pick: lowest requester above r_ptr, else lowest overall (wrap).
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (bus.i_req[k] && (PTR_W'(k) > r_ptr)) begin
                w_win = PTR_W'(k);
                w_any = 1'b1;
            end
        end
        if (!w_any) begin
            for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
                if (bus.i_req[k]) begin
                    w_win = PTR_W'(k);
                    w_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_win_msg  = '0;
        w_win_data = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (PTR_W'(k) == w_win) begin
                w_win_msg  = bus.i_req_msg[k*MSG_W +: MSG_W];
                w_win_data = bus.i_req_has_data[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state             <= S_IDLE;
            r_ptr               <= PTR_W'(N_REQ - 1);
            r_to_cnt            <= '0;
            r_gap_cnt           <= '0;
            r_grant             <= '0;
            r_msg_valid         <= 1'b0;
            r_data_valid        <= 1'b0;
            r_msg               <= '0;
            r_start_pattern_req <= 1'b0;
            r_arb_busy          <= 1'b0;
            r_start_err         <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_grant             <= '0;
            r_msg_valid         <= 1'b0;
            r_data_valid        <= 1'b0;
            r_start_pattern_req <= 1'b0;
            r_start_err         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_pattern_req) begin
                        r_start_pattern_req <= 1'b1;
                        r_arb_busy          <= 1'b1;
                        r_state             <= S_PAT;
                    end else if (w_any) begin
                        r_ptr        <= w_win;
                        r_msg        <= w_win_msg;
                        r_grant      <= N_REQ'(1) << w_win;
                        r_msg_valid  <= 1'b1;
                        r_data_valid <= w_win_data;
                        r_arb_busy   <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_PAT: begin
                    if (bus.i_pattern_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (bus.i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == TO_W'(START_TO - 1)) begin
                        // Packet dropped: FSM never started it.
                        r_start_err <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end else if (r_to_cnt != '1) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.i_tx_busy) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_grant             = r_grant;
    assign bus.o_msg_valid         = r_msg_valid;
    assign bus.o_data_valid        = r_data_valid;
    assign bus.o_msg               = r_msg;
    assign bus.o_start_pattern_req = r_start_pattern_req;
    assign bus.o_arb_busy          = r_arb_busy;
    assign bus.o_start_err         = r_start_err;
endmodule
